fft8_in_buf: RTL and testbench

Upstream input stage for the fft8 butterfly core. It accepts a serial stream of 10-bit signed complex samples under a valid/ready handshake. It assembles them into 8-point frames in a ping-pong (two-bank) buffer and presents each completed frame as the packed 80-bit `dinre`/`dinim` vectors that fft8 consumes. It also checks frame alignment against an end-of-frame marker and flags misalignment.

---
 rtl/fft_pkg.sv | 19 +
 rtl/fft8_bank.sv | 51 +++++
 rtl/fft8_in_buf.sv | 92 +++++++++
 tb/tb_fft8_in_buf.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and constants for the fft8 datapath: sample width, frame size,
// the complex sample struct and the packed-vector slicing helper.
package fft_pkg;

  localparam int W     = 10;
  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  // LSB position of sample k inside an N*W packed vector (sample 0 in the LSBs).
  function automatic int unsigned lsb_of(input int unsigned k);
    return k * W;
  endfunction

endpackage

// File: rtl/fft8_bank.sv
// One N-entry complex sample bank with indexed write, a full flag and
// packed real/imag read vectors in fft8 dinre/dinim order.
module fft8_bank
  import fft_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IDX_W-1:0] widx_i,
  input  cplx_t            wdata_i,
  input  logic             set_full_i,
  input  logic             clr_full_i,
  output logic             full_o,
  output logic [N*W-1:0]   re_o,
  output logic [N*W-1:0]   im_o
);

  logic full_q;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_entry
      cplx_t entry_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          entry_q <= '0;
        end else if (we_i && (widx_i == IDX_W'(gi))) begin
          entry_q <= wdata_i;
        end
      end

      assign re_o[lsb_of(gi) +: W] = entry_q.re;
      assign im_o[lsb_of(gi) +: W] = entry_q.im;
    end
  endgenerate

  // Set and clear never target the same bank in one cycle: a bank is only
  // filled while empty and only drained while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (set_full_i) begin
      full_q <= 1'b1;
    end else if (clr_full_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;

endmodule

// File: rtl/fft8_in_buf.sv
// Ping-pong input buffer for fft8: assembles a serial complex sample stream into
// 8-point frames, presents them as packed vectors and flags frame misalignment.
module fft8_in_buf
  import fft_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_re,
  input  logic [W-1:0]   s_im,
  input  logic           s_last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N*W-1:0] m_re,
  output logic [N*W-1:0] m_im,
  output logic           sync_err
);

  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sync_err_q, sync_err_d;

  logic             accept, last_slot, early_last, wr_en, frame_done, drain;
  logic [1:0]       full;
  logic [N*W-1:0]   bank_re [2];
  logic [N*W-1:0]   bank_im [2];
  cplx_t            wdata;

  assign wdata = '{re: s_re, im: s_im};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      fft8_bank u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (wr_en && (wr_bank_q == 1'(gi))),
        .widx_i     (idx_q),
        .wdata_i    (wdata),
        .set_full_i (frame_done && (wr_bank_q == 1'(gi))),
        .clr_full_i (drain && (rd_bank_q == 1'(gi))),
        .full_o     (full[gi]),
        .re_o       (bank_re[gi]),
        .im_o       (bank_im[gi])
      );
    end
  endgenerate

  assign s_ready = !full[wr_bank_q];
  assign m_valid = full[rd_bank_q];
  assign m_re    = bank_re[rd_bank_q];
  assign m_im    = bank_im[rd_bank_q];
  assign sync_err = sync_err_q;

  // An early s_last drops the partial frame without writing the marker sample.
  assign accept     = s_valid && s_ready;
  assign last_slot  = (idx_q == IDX_W'(N - 1));
  assign early_last = accept && s_last && !last_slot;
  assign wr_en      = accept && !early_last;
  assign frame_done = accept && last_slot;
  assign drain      = m_valid && m_ready;

  always_comb begin
    wr_bank_d  = wr_bank_q ^ frame_done;
    rd_bank_d  = rd_bank_q ^ drain;
    idx_d      = idx_q;
    sync_err_d = early_last || (frame_done && !s_last);
    if (accept) begin
      if (last_slot || s_last) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      idx_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      idx_q      <= idx_d;
      sync_err_q <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_fft8_in_buf.sv
// Scoreboard bench for fft8_in_buf: stimulus pushes expected frames, a negedge
// monitor pops and compares on every output transfer.
module tb_fft8_in_buf;

  localparam int W = 10;
  localparam int N = 8;

  typedef struct {
    logic [N*W-1:0] re;
    logic [N*W-1:0] im;
  } frame_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           s_valid, s_ready, s_last;
  logic [W-1:0]   s_re, s_im;
  logic           m_valid, m_ready;
  logic [N*W-1:0] m_re, m_im;
  logic           sync_err;

  int checks = 0;
  int errors = 0;
  int sync_cnt = 0;
  int mv_cnt = 0;
  int stall_cnt = 0;
  frame_t exp_q [$];

  always #5 clk = ~clk;

  fft8_in_buf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_re     (s_re),
    .s_im     (s_im),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_re     (m_re),
    .m_im     (m_im),
    .sync_err (sync_err)
  );

  // Monitor: compares every output transfer against the head of the scoreboard.
  always @(negedge clk) begin
    frame_t e;
    if (rst_n) begin
      if (sync_err) sync_cnt++;
      if (m_valid) mv_cnt++;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame got re=%h im=%h required none", m_re, m_im);
        end else begin
          e = exp_q.pop_front();
          if (m_re !== e.re || m_im !== e.im) begin
            errors++;
            $display("FAIL frame_data got re=%h im=%h required re=%h im=%h",
                     m_re, m_im, e.re, e.im);
          end else begin
            $display("frame ok re=%h im=%h", m_re, m_im);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [N*W-1:0] got, input logic [N*W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h required %h", name, got, want);
    end else begin
      $display("check %s ok value %h", name, got);
    end
  endtask

  task automatic push_frame(input int re_v [N], input int im_v [N]);
    frame_t f;
    for (int k = 0; k < N; k++) begin
      f.re[k*W +: W] = 10'(re_v[k]);
      f.im[k*W +: W] = 10'(im_v[k]);
    end
    exp_q.push_back(f);
  endtask

  // Entered and left at posedge+1; holds the sample until it is accepted.
  task automatic send(input int re, input int im, input logic last);
    int  waits;
    bit  done;
    waits = 0;
    done  = 0;
    s_valid = 1'b1;
    s_re    = 10'(re);
    s_im    = 10'(im);
    s_last  = last;
    while (!done) begin
      @(negedge clk);
      if (s_ready) done = 1;
      else waits++;
      @(posedge clk);
      #1;
      if (!done && waits > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got s_ready=0 for %0d cycles required 1", waits);
        done = 1;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    stall_cnt += waits;
  endtask

  task automatic send_frame(input int re_v [N], input int im_v [N], input bit mark_last);
    for (int k = 0; k < N; k++) begin
      send(re_v[k], im_v[k], mark_last && (k == N - 1));
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int re_v [N];
    int im_v [N];
    int sync0, mv0, acc;

    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_re = '0; s_im = '0; m_ready = 1'b0;
    #12;
    chk("reset_s_ready", 80'(s_ready), 80'(1));
    chk("reset_m_valid", 80'(m_valid), 80'(0));
    chk("reset_m_re", m_re, '0);
    chk("reset_sync_err", 80'(sync_err), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single frame with latency and field checks
    m_ready = 1'b1;
    sync0 = sync_cnt; mv0 = mv_cnt;
    re_v = '{3, -13, -4, 3, 36, 28, -13, 30};
    im_v = '{7, -12, 7, 16, 5, 10, 7, -3};
    push_frame(re_v, im_v);
    send_frame(re_v, im_v, 1'b1);
    @(negedge clk);
    chk("single_m_valid", 80'(m_valid), 80'(1));
    chk("single_re0", 80'(m_re[9:0]), 80'(10'd3));
    chk("single_re7", 80'(m_re[79:70]), 80'(10'd30));
    chk("single_im7", 80'(m_im[79:70]), 80'(10'h3FD));
    idle(4);
    chk("single_valid_cycles", 80'(mv_cnt - mv0), 80'(1));
    chk("single_sync", 80'(sync_cnt - sync0), 80'(0));

    // Back-pressure: 20 offered, 16 accepted
    m_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1;
      s_re = 10'(i);
      s_im = 10'(-i);
      s_last = ((acc % 8) == 7);
      @(negedge clk);
      if (s_ready) acc++;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("bp_accepted", 80'(acc), 80'(16));
    @(negedge clk);
    chk("bp_s_ready_low", 80'(s_ready), 80'(0));
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < N; k++) begin
        re_v[k] = 8 * f + k;
        im_v[k] = -(8 * f + k);
      end
      push_frame(re_v, im_v);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("bp_s_ready_back", 80'(s_ready), 80'(1));
    chk("bp_frame1_pending", 80'(m_valid), 80'(1));
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    idle(3);

    // Full rate: 64 samples, no stalls, 8 ordered frames
    stall_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < N; k++) begin
        re_v[k] = 8 * f + k;
        im_v[k] = 100 - (8 * f + k);
      end
      push_frame(re_v, im_v);
    end
    for (int v = 0; v < 64; v++) begin
      send(v, 100 - v, (v % 8) == 7);
    end
    chk("fullrate_stalls", 80'(stall_cnt), 80'(0));
    idle(4);
    chk("fullrate_drained", 80'(exp_q.size()), 80'(0));

    // Early s_last on the 5th sample, then a clean frame
    sync0 = sync_cnt;
    for (int k = 0; k < 5; k++) send(200 + k, -200 - k, k == 4);
    for (int k = 0; k < N; k++) begin
      re_v[k] = 40 + k;
      im_v[k] = 50 - k;
    end
    push_frame(re_v, im_v);
    send_frame(re_v, im_v, 1'b1);
    idle(4);
    chk("early_last_sync", 80'(sync_cnt - sync0), 80'(1));

    // Missing s_last: frame still completes
    sync0 = sync_cnt;
    for (int k = 0; k < N; k++) begin
      re_v[k] = -100 + 7 * k;
      im_v[k] = 255 - 3 * k;
    end
    push_frame(re_v, im_v);
    send_frame(re_v, im_v, 1'b0);
    idle(4);
    chk("missing_last_sync", 80'(sync_cnt - sync0), 80'(1));

    // Reset mid-frame with a full frame pending
    m_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      re_v[k] = 1 + k;
      im_v[k] = 1 + k;
    end
    send_frame(re_v, im_v, 1'b1);
    for (int k = 0; k < 5; k++) send(90 + k, 90 + k, 1'b0);
    @(negedge clk);
    chk("prereset_m_valid", 80'(m_valid), 80'(1));
    #1;
    rst_n = 1'b0;
    #2;
    chk("midreset_m_valid", 80'(m_valid), 80'(0));
    chk("midreset_m_re", m_re, '0);
    chk("midreset_s_ready", 80'(s_ready), 80'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      re_v[k] = -20 - k;
      im_v[k] = 20 + 11 * k;
    end
    push_frame(re_v, im_v);
    send_frame(re_v, im_v, 1'b1);
    idle(6);
    chk("final_queue_empty", 80'(exp_q.size()), 80'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
